hv_bundler: RTL and testbench
=============================

HV_BUNDLER -- requirements
Module: hv_bundler

Interface
- REQ-001: Parameter HVDimension, default 512; hypervector width; matches the item-memory and encoder HV width.
- REQ-002: Parameter CounterWidth, default 8; signed per-bit accumulator width; legal range 2..16.
- REQ-003: Parameter BundleLenWidth, default 16; width of the bundle-length configuration and the accumulated-count output.
- REQ-004: clk_i  input  1  clock; all state updates on the rising edge.
- REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
- REQ-006: clr_i  input  1  synchronous clear of all accumulators, the accumulated count and the FSM.
- REQ-007: bundle_len_i  input  BundleLenWidth  number of HVs per bundle; the value 0 is treated as 1.
- REQ-008: hv_i  input  HVDimension  input hypervector from the encoder.
- REQ-009: hv_valid_i  input  1  hv_i is valid.
- REQ-010: hv_ready_o  output  1  block accepts hv_i.
- REQ-011: hv_o  output  HVDimension  binarized bundled hypervector.
- REQ-012: hv_valid_o  output  1  hv_o is valid.
- REQ-013: hv_ready_i  input  1  downstream accepts hv_o.
- REQ-014: acc_count_o  output  BundleLenWidth  number of HVs accumulated into the current bundle.

Function
- REQ-015: The FSM shall have exactly two states: ACCUM and OUTPUT.
- REQ-016: In ACCUM, hv_ready_o shall be 1 and hv_valid_o shall be 0.
- REQ-017: In OUTPUT, hv_ready_o shall be 0 and hv_valid_o shall be 1.
- REQ-018: An input accept (hv_valid_i && hv_ready_o) shall update every bit i in the same clock edge:
  - hv_i[i]=1: counter i += 1
  - hv_i[i]=0: counter i -= 1
- REQ-019: Each counter shall saturate at +(2^(CounterWidth-1)-1) and at -(2^(CounterWidth-1)); it shall never wrap.
- REQ-020: Each input accept shall increment acc_count_o by 1.
- REQ-021: When an accept makes acc_count_o equal to the effective bundle length, the FSM shall enter OUTPUT on that clock edge; hv_valid_o rises the cycle after the last accept (1-cycle latency).
- REQ-022: hv_o[i] shall be 1 when counter i > 0; otherwise 0 (a tie of 0 resolves to 0).
- REQ-023: hv_o shall be combinationally derived from the counters and shall stay stable throughout OUTPUT.
- REQ-024: hv_o shall read all-zero whenever hv_valid_o=0.
- REQ-025: An output handshake (hv_valid_o && hv_ready_i) shall:
  - zero all counters,
  - zero acc_count_o,
  - return the FSM to ACCUM on the same edge.
- REQ-026: hv_valid_o, once high, shall remain high until the output handshake (no withdrawal).
- REQ-027: clr_i=1 shall, on that edge:
  - zero all counters and acc_count_o,
  - force ACCUM,
  - discard any pending output.
- REQ-028: clr_i shall have priority over a simultaneous input accept or output handshake; during a clr_i cycle the input data is ignored, though hv_ready_o remains as REQ-016/017 define.
- REQ-029: bundle_len_i shall be sampled on every accept; a change mid-bundle takes effect at the next comparison.
- REQ-030: If acc_count_o already ≥ a reduced bundle_len_i, the next accept shall end the bundle.

Reset
- REQ-031: On rst_ni=0, asynchronously:
  - FSM=ACCUM,
  - all counters=0,
  - acc_count_o=0,
  - hv_valid_o=0,
  - hv_o=0.
- REQ-032: After reset release, hv_ready_o shall be 1 in the first cycle.
- REQ-033: Reset asserted mid-bundle or during OUTPUT shall discard all state without producing an output.

Structure
- REQ-034: The shared package hv_pkg shall hold the FSM state typedef (ACCUM, OUTPUT) and the default CounterWidth and BundleLenWidth constants.
- REQ-035: The per-bit accumulator shall be one sub-module, hv_sat_counter:
  - inputs: clk_i, rst_ni, clr_i, en_i, up_i;
  - outputs: signed count and sign bit;
  - instantiated HVDimension times via generate.

Verification
- REQ-036: bundle_len_i=3, HVDimension=8, inputs 0xF0, 0xCC, 0xAA accepted back-to-back -> hv_valid_o one cycle after the third accept, hv_o=0xE8, acc_count_o=3.
- REQ-037: bundle_len_i=2, inputs 0xFF then 0x00 -> hv_o=0x00 (all ties resolve to 0).
- REQ-038: CounterWidth=4, bundle_len_i=20, all-ones input for 20 accepts -> counters hold at +7 with no wrap, hv_o=all-ones; mirror test with all-zeros holds at -8.
- REQ-039: hv_ready_i=0 held for 5 cycles in OUTPUT -> hv_valid_o and hv_o stable, hv_ready_o=0; a new hv_valid_i is not accepted; after hv_ready_i=1, next cycle in ACCUM with counters=0.
- REQ-040: clr_i asserted together with hv_valid_i at acc_count_o=1 of 4 -> acc_count_o=0, input dropped; then 4 fresh accepts produce one bundle.
- REQ-041: bundle_len_i=0 and rst_ni pulsed mid-OUTPUT -> bundle after every single accept with hv_o=hv_i; reset returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/hv_pkg.sv
// Shared types and default widths for the hypervector bundling datapath.
package hv_pkg;

    typedef enum logic {
        ACCUM,
        OUTPUT
    } state_e;

    localparam int unsigned DefCounterWidth   = 8;
    localparam int unsigned DefBundleLenWidth = 16;

endpackage

// File: rtl/hv_sat_counter.sv
// Per-bit signed up/down accumulator that saturates at both extremes instead of wrapping.
module hv_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    up_i,
    output logic signed [Width-1:0] count_o,
    output logic                    sign_o
);

    localparam logic signed [Width-1:0] CntMax = {1'b0, {(Width-1){1'b1}}};
    localparam logic signed [Width-1:0] CntMin = {1'b1, {(Width-1){1'b0}}};
    localparam logic signed [Width-1:0] CntOne = {{(Width-1){1'b0}}, 1'b1};

    logic signed [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (up_i && (count_q != CntMax)) begin
                count_d = count_q + CntOne;
            end else if (!up_i && (count_q != CntMin)) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign sign_o  = count_q[Width-1];

endmodule

// File: rtl/hv_bundler.sv
// Bundles a configurable number of hypervectors by per-bit majority and presents the
// binarized result through a valid/ready output handshake.
module hv_bundler
    import hv_pkg::*;
#(
    parameter int unsigned HVDimension    = 512,
    parameter int unsigned CounterWidth   = DefCounterWidth,
    parameter int unsigned BundleLenWidth = DefBundleLenWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic [BundleLenWidth-1:0] bundle_len_i,
    input  logic [HVDimension-1:0]    hv_i,
    input  logic                      hv_valid_i,
    output logic                      hv_ready_o,
    output logic [HVDimension-1:0]    hv_o,
    output logic                      hv_valid_o,
    input  logic                      hv_ready_i,
    output logic [BundleLenWidth-1:0] acc_count_o
);

    localparam logic [BundleLenWidth-1:0] LenOne = {{(BundleLenWidth-1){1'b0}}, 1'b1};

    state_e                    state_q;
    logic [BundleLenWidth-1:0] acc_q;
    logic                      valid_q;
    logic                      ready_q;

    logic                      accept;
    logic                      out_hs;
    logic                      cnt_clr;
    logic [BundleLenWidth-1:0] eff_len;
    logic [BundleLenWidth-1:0] acc_inc;
    logic [HVDimension-1:0]    pos;

    assign accept  = hv_valid_i & ready_q & ~clr_i;
    assign out_hs  = valid_q & hv_ready_i;
    assign cnt_clr = clr_i | out_hs;
    assign eff_len = (bundle_len_i == '0) ? LenOne : bundle_len_i;
    assign acc_inc = acc_q + LenOne;

    // >= rather than == so a length reduced below the running count ends the bundle next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (clr_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_inc;
                        if (acc_inc >= eff_len) begin
                            state_q <= OUTPUT;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_hs) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < HVDimension; i++) begin : g_bit
        logic signed [CounterWidth-1:0] cnt;
        logic                           sign;

        hv_sat_counter #(
            .Width (CounterWidth)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (cnt_clr),
            .en_i    (accept),
            .up_i    (hv_i[i]),
            .count_o (cnt),
            .sign_o  (sign)
        );

        // Strictly positive: a zero tie binarizes to 0.
        assign pos[i] = ~sign & (|cnt);
    end

    assign hv_ready_o  = ready_q;
    assign hv_valid_o  = valid_q;
    assign hv_o        = valid_q ? pos : '0;
    assign acc_count_o = acc_q;

endmodule

// File: tb/tb_hv_bundler.sv
// Directed self-checking bench for hv_bundler with an 8-bit hypervector and 4-bit counters.
module tb_hv_bundler;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic [15:0] bundle_len_i;
    logic [7:0]  hv_i;
    logic        hv_valid_i;
    logic        hv_ready_o;
    logic [7:0]  hv_o;
    logic        hv_valid_o;
    logic        hv_ready_i;
    logic [15:0] acc_count_o;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    hv_bundler #(
        .HVDimension    (8),
        .CounterWidth   (4),
        .BundleLenWidth (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .bundle_len_i (bundle_len_i),
        .hv_i         (hv_i),
        .hv_valid_i   (hv_valid_i),
        .hv_ready_o   (hv_ready_o),
        .hv_o         (hv_o),
        .hv_valid_o   (hv_valid_o),
        .hv_ready_i   (hv_ready_i),
        .acc_count_o  (acc_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        hv_i       = v;
        hv_valid_i = 1'b1;
        @(posedge clk);
        #1;
        hv_valid_i = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        hv_ready_i = 1'b1;
        @(posedge clk);
        #1;
        hv_ready_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_hv, input logic [15:0] exp_acc);
        chk({tag, "_valid"}, 32'(hv_valid_o), 32'd1);
        chk({tag, "_hv"},    32'(hv_o),       32'(exp_hv));
        chk({tag, "_acc"},   32'(acc_count_o), 32'(exp_acc));
    endtask

    initial begin
        rst_ni       = 1'b0;
        clr_i        = 1'b0;
        bundle_len_i = 16'd3;
        hv_i         = 8'h00;
        hv_valid_i   = 1'b0;
        hv_ready_i   = 1'b0;

        #1;
        chk("rst_valid", 32'(hv_valid_o), 32'd0);
        chk("rst_hv",    32'(hv_o),       32'd0);
        chk("rst_acc",   32'(acc_count_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", 32'(hv_ready_o), 32'd1);

        // Majority of three: F0, CC, AA -> E8
        bundle_len_i = 16'd3;
        send(8'hF0);
        chk("maj_mid_valid", 32'(hv_valid_o), 32'd0);
        chk("maj_mid_hv",    32'(hv_o),       32'd0);
        chk("maj_mid_acc",   32'(acc_count_o), 32'd1);
        send(8'hCC);
        chk("maj_2nd_valid", 32'(hv_valid_o), 32'd0);
        send(8'hAA);
        check_out("maj", 8'hE8, 16'd3);
        chk("maj_ready", 32'(hv_ready_o), 32'd0);
        drain();
        chk("maj_drain_valid", 32'(hv_valid_o), 32'd0);
        chk("maj_drain_acc",   32'(acc_count_o), 32'd0);
        chk("maj_drain_ready", 32'(hv_ready_o), 32'd1);
        chk("maj_drain_hv",    32'(hv_o),       32'd0);

        // Ties resolve to 0
        bundle_len_i = 16'd2;
        send(8'hFF);
        send(8'h00);
        check_out("tie", 8'h00, 16'd2);
        drain();

        // Saturation at +7 / -8 with 4-bit counters
        bundle_len_i = 16'd20;
        repeat (20) send(8'hFF);
        check_out("sat_pos20", 8'hFF, 16'd20);
        drain();
        repeat (20) send(8'h00);
        check_out("sat_neg20", 8'h00, 16'd20);
        drain();
        bundle_len_i = 16'd11;
        repeat (10) send(8'hFF);
        send(8'h00);
        check_out("sat_pos_nowrap", 8'hFF, 16'd11);
        drain();
        repeat (10) send(8'h00);
        send(8'hFF);
        check_out("sat_neg_nowrap", 8'h00, 16'd11);
        drain();
        bundle_len_i = 16'd14;
        repeat (8) send(8'hFF);
        repeat (6) send(8'h00);
        check_out("sat_pos_level", 8'hFF, 16'd14);
        drain();
        bundle_len_i = 16'd17;
        repeat (9) send(8'h00);
        repeat (8) send(8'hFF);
        check_out("sat_neg_level", 8'h00, 16'd17);
        drain();

        // Backpressure: output held, new input refused
        bundle_len_i = 16'd3;
        send(8'hF0);
        send(8'hCC);
        send(8'hAA);
        @(negedge clk);
        hv_i       = 8'h00;
        hv_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_out("stall", 8'hE8, 16'd3);
            chk("stall_ready", 32'(hv_ready_o), 32'd0);
        end
        hv_valid_i = 1'b0;
        drain();
        chk("stall_drain_ready", 32'(hv_ready_o), 32'd1);
        chk("stall_drain_acc",   32'(acc_count_o), 32'd0);
        bundle_len_i = 16'd1;
        send(8'h0F);
        check_out("stall_cleared", 8'h0F, 16'd1);
        drain();

        // clr_i beats a simultaneous accept
        bundle_len_i = 16'd4;
        send(8'h55);
        chk("clr_pre_acc", 32'(acc_count_o), 32'd1);
        @(negedge clk);
        clr_i      = 1'b1;
        hv_i       = 8'hFF;
        hv_valid_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i      = 1'b0;
        hv_valid_i = 1'b0;
        chk("clr_acc",   32'(acc_count_o), 32'd0);
        chk("clr_valid", 32'(hv_valid_o), 32'd0);
        chk("clr_ready", 32'(hv_ready_o), 32'd1);
        send(8'h0F);
        send(8'hF0);
        send(8'h0F);
        chk("clr_3rd_valid", 32'(hv_valid_o), 32'd0);
        chk("clr_3rd_acc",   32'(acc_count_o), 32'd3);
        send(8'hF0);
        check_out("clr_fresh", 8'h00, 16'd4);
        drain();

        // Length reduced below running count ends bundle on next accept
        bundle_len_i = 16'd5;
        repeat (3) send(8'hFF);
        chk("shrink_pre_valid", 32'(hv_valid_o), 32'd0);
        bundle_len_i = 16'd2;
        send(8'h00);
        check_out("shrink", 8'hFF, 16'd4);
        drain();

        // Length 0 behaves as 1; async reset mid-OUTPUT
        bundle_len_i = 16'd0;
        send(8'hA5);
        check_out("len0_a", 8'hA5, 16'd1);
        drain();
        send(8'h3C);
        check_out("len0_b", 8'h3C, 16'd1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(hv_valid_o), 32'd0);
        chk("arst_hv",    32'(hv_o),       32'd0);
        chk("arst_acc",   32'(acc_count_o), 32'd0);
        chk("arst_ready", 32'(hv_ready_o), 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("arst_rel_ready", 32'(hv_ready_o), 32'd1);
        send(8'h01);
        check_out("len0_after_rst", 8'h01, 16'd1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
